// File: rtl/sysarr_pkg.sv
// rtl/sysarr_pkg.sv - shared systolic array geometry and column slice helper
package sysarr_pkg;

   localparam int SYS_N = 8;
   localparam int SYS_W = 1;

   // LSB of column j in a packed row of w-bit elements
   function automatic int col_lsb(input int j, input int w);
      return j * w;
   endfunction

endpackage

// File: rtl/drain_delay_line.sv
// rtl/drain_delay_line.sv - LEN-stage shift register, LEN=0 is a wire
module drain_delay_line #(
   parameter int LEN = 1,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (LEN == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign q = d;
      end else begin : g_shift
         logic [W-1:0] stage [LEN];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LEN; i++) stage[i] <= '0;
            end else begin
               stage[0] <= d;
               for (int i = 1; i < LEN; i++) stage[i] <= stage[i-1];
            end
         end
         assign q = stage[LEN-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_drain_deskew.sv
// rtl/systolic_drain_deskew.sv - realigns skewed array rows into a small output FIFO
module systolic_drain_deskew
   import sysarr_pkg::*;
#(
   parameter int N     = SYS_N,
   parameter int W     = SYS_W,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           in_valid,
   input  logic [N*W-1:0] in_cols,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] out_row,
   output logic           overflow,
   output logic [7:0]     row_count
);

   localparam int AW = $clog2(DEPTH);

   logic [N*W-1:0] al_row;
   logic           al_valid;

   // Column j arrives j cycles late, so it needs j fewer stages than column 0
   for (genvar j = 0; j < N; j++) begin : g_col
      drain_delay_line #(.LEN(N-1-j), .W(W)) u_col (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (in_cols[col_lsb(j, W) +: W]),
         .q     (al_row[col_lsb(j, W) +: W])
      );
   end

   drain_delay_line #(.LEN(N-1), .W(1)) u_valid (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_valid),
      .q     (al_valid)
   );

   logic [N*W-1:0] mem [DEPTH];
   logic [AW:0]    wr_ptr, rd_ptr, wr_next, rd_next;
   logic           full, empty, pop, push_ok;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign push_ok   = al_valid && (!full || pop);
   assign wr_next   = wr_ptr + (AW+1)'(push_ok);
   assign rd_next   = rd_ptr + (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (push_ok && !clr) mem[wr_ptr[AW-1:0]] <= al_row;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_row   <= '0;
         overflow  <= 1'b0;
         row_count <= '0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         row_count <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (pop) row_count <= row_count + 8'd1;
         if (al_valid && !push_ok) overflow <= 1'b1;
         // Preload the next head; it is the incoming row when it lands in the head slot
         if (wr_next != rd_next) begin
            if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) out_row <= al_row;
            else out_row <= mem[rd_next[AW-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// tb/tb_systolic_drain_deskew.sv - directed scoreboard bench for systolic_drain_deskew
module tb_systolic_drain_deskew;

   logic       clk, rst_n, clr, in_valid, out_valid, out_ready, overflow;
   logic [7:0] in_cols, out_row, row_count;

   systolic_drain_deskew dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_cols   (in_cols),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .overflow  (overflow),
      .row_count (row_count)
   );

   always #5 clk = ~clk;

   int         n_assert, n_fail, cyc, vcnt, vfirst, s;
   logic [7:0] rowmap [int];
   logic [7:0] exp_q [$];
   logic [7:0] held_row;
   bit         stalled, prev_clr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Column j of the row started at cycle c appears on in_cols at c+j
   task automatic drive();
      logic [7:0] c, r;
      c = '0;
      for (int j = 0; j < 8; j++) begin
         if (rowmap.exists(cyc - j)) begin
            r = rowmap[cyc - j];
            c[j] = r[j];
         end
      end
      in_cols  = c;
      in_valid = (rowmap.exists(cyc) != 0);
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         if (out_valid) begin
            vcnt++;
            if (vfirst < 0) vfirst = cyc;
         end
         if (stalled && !prev_clr) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_row", 32'(out_row), 32'(held_row));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("row_without_expectation", 32'(exp_q.size()), 1);
            else chk("row", 32'(out_row), 32'(exp_q.pop_front()));
         end
         stalled  = out_valid && !out_ready;
         held_row = out_row;
         prev_clr = clr;
      end else begin
         stalled = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] d, input bit keep);
      rowmap[cyc + 1] = d;
      if (keep) exp_q.push_back(d);
      step();
   endtask

   task automatic pulse_clr();
      clr = 1;
      step();
      clr = 0;
   endtask

   initial begin
      clk = 0; rst_n = 0; clr = 0; in_valid = 0; in_cols = '0; out_ready = 1;
      n_assert = 0; n_fail = 0; cyc = 0; vcnt = 0; vfirst = -1;
      stalled = 0; prev_clr = 0; held_row = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_row", 32'(out_row), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_count", 32'(row_count), 0);

      // single all-ones row: visible exactly one cycle, N cycles after in_valid
      vfirst = -1; vcnt = 0;
      s = cyc + 1;
      send(8'hFF, 1);
      run(10);
      chk("single_first_cycle", 32'(vfirst), 32'(s + 8));
      chk("single_valid_cycles", 32'(vcnt), 1);
      chk("single_count", 32'(row_count), 1);

      // back-to-back skewed alternating rows
      send(8'hAA, 1);
      send(8'h55, 1);
      run(12);
      chk("skew_count", 32'(row_count), 3);

      // backpressure: fifth row overflows
      pulse_clr();
      out_ready = 0;
      send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1); send(8'h05, 0);
      run(7);
      chk("bp_ovf_before", 32'(overflow), 0);
      step();
      chk("bp_ovf_after", 32'(overflow), 1);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_head", 32'(out_row), 32'h01);
      out_ready = 1;
      run(8);
      chk("bp_count", 32'(row_count), 4);
      chk("bp_ovf_sticky", 32'(overflow), 1);
      chk("bp_drained", 32'(exp_q.size()), 0);

      // full FIFO with a pop on the cycle the fifth row aligns
      pulse_clr();
      chk("clr_ovf", 32'(overflow), 0);
      out_ready = 0;
      send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1); send(8'h55, 1);
      run(7);
      out_ready = 1;
      step();
      chk("fp_ovf", 32'(overflow), 0);
      run(8);
      chk("fp_count", 32'(row_count), 5);
      chk("fp_drained", 32'(exp_q.size()), 0);

      // clr flushes buffered rows but not a row still in the delay lines
      out_ready = 0;
      send(8'hA1, 1); send(8'hA2, 1); send(8'hA3, 1);
      run(5);
      send(8'hA4, 1);
      run(3);
      chk("pre_clr_valid", 32'(out_valid), 1);
      pulse_clr();
      repeat (3) void'(exp_q.pop_front());
      chk("clr_valid", 32'(out_valid), 0);
      chk("clr_count", 32'(row_count), 0);
      chk("clr_ovf2", 32'(overflow), 0);
      out_ready = 1;
      run(8);
      chk("clr_inflight_count", 32'(row_count), 1);
      chk("clr_drained", 32'(exp_q.size()), 0);

      // asynchronous reset mid-row
      out_ready = 0;
      send(8'hC3, 0);
      run(9);
      chk("pre_rst_valid", 32'(out_valid), 1);
      send(8'h3C, 0);
      run(3);
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_row", 32'(out_row), 0);
      chk("arst_ovf", 32'(overflow), 0);
      chk("arst_count", 32'(row_count), 0);
      step();
      step();
      rst_n = 1;
      out_ready = 1;
      vcnt = 0;
      run(15);
      chk("post_rst_no_row", 32'(vcnt), 0);
      chk("post_rst_count", 32'(row_count), 0);
      send(8'h5A, 1);
      run(10);
      chk("post_rst_new_row", 32'(row_count), 1);
      chk("final_drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
